ttfir_cfg_ctrl: RTL and testbench
=================================

# ttfir_cfg_ctrl

Configuration sequencer for the ttfir datapath. It receives FIR coefficients over a 3-pin serial protocol, which is all the 8-bit tile I/O leaves after clock, reset and samples. It checks an even-parity bit, commits the coefficients atomically to the coefficient bus, and flushes the delay line. Only then does it enable filtering. It sits between io_in and the FIR core inside gbsha_top.

## Interface

- N_TAPS, 2, number of FIR taps (≥1)
- BW_coef, 4, bits per coefficient (≥1)

Ports:

- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- cfg_mode  input  1  configuration request; a rising edge starts a load; low during a load aborts it
- cfg_valid  input  1  qualifies cfg_bit for the current cycle
- cfg_bit  input  1  serial data, MSB-first, parity bit last
- coef_flat  output  N_TAPS*BW_coef  active coefficients; tap k is bits [(k+1)*BW_coef-1 : k*BW_coef]
- fir_en  output  1  FIR datapath enable
- fir_clr  output  1  synchronous clear of the FIR delay line and accumulator
- cfg_done  output  1  last load committed successfully
- cfg_err  output  1  last load failed (parity or abort)

## Operation

- L = N_TAPS*BW_coef + 1 frame bits. Shift register is L bits. Bit counter is ceil(log2(L+1)) bits.
- mode_q is a registered copy of cfg_mode. start = cfg_mode & ~mode_q.
- loaded flag: set on the first commit, cleared only by reset.
- All outputs are registered. Reset values: coef_flat=0, fir_en=0, fir_clr=0, cfg_done=0, cfg_err=0. Reset also sets state=IDLE, loaded=0, shift=0, count=0, mode_q=0.
- States: IDLE, LOAD, CHECK, FLUSH, RUN.
- IDLE: fir_en=0.
  - start → LOAD.
- LOAD entry: count=0, shift=0, cfg_done=0, cfg_err=0, fir_en=0.
- In LOAD:
  - Each cycle with cfg_valid=1: shift <= {shift[L-2:0], cfg_bit}; count++.
  - When the accepted bit makes count=L → CHECK.
  - cfg_valid=0 cycles are ignored; there is no timeout.
  - cfg_mode=0 before count=L → abort. cfg_err=1; coef_flat unchanged; go to RUN if loaded, else IDLE.
  - If cfg_mode falls on the same cycle the L-th bit is accepted, the frame completes (completion wins).
- CHECK (1 cycle), with cfg_mode ignored:
  - XOR of shift == 0: coef_flat <= shift[L-1:1], cfg_done=1, loaded=1 → FLUSH.
  - Otherwise: cfg_err=1, coef_flat unchanged → RUN if loaded, else IDLE.
- FLUSH: fir_clr=1 and fir_en=0 for exactly N_TAPS cycles; cfg_mode ignored.
  - Then fir_clr=0 → RUN.
- RUN: fir_en=1.
  - start → LOAD, with fir_en deasserted from that edge.
- Bit order: the first bit shifted in lands at coef_flat MSB, i.e. tap N_TAPS-1 bit BW_coef-1.
- cfg_done and cfg_err are sticky. Both clear only on the next LOAD entry or on reset. They are never both 1.
- A start edge is required for every load. Holding cfg_mode high after completion does not retrigger.

## Timing

- Edge e0 sees start in IDLE/RUN. State is LOAD after e0, and fir_en=0 after e0.
- Edge eL accepts the L-th valid bit. State is CHECK after eL.
- Edge eL+1: coef_flat, cfg_done and fir_clr update together. State is FLUSH.
- fir_clr stays high for edges eL+1 … eL+N_TAPS.
- Edge eL+N_TAPS+1: fir_clr=0, fir_en=1.
- Minimum reconfiguration time from start to fir_en=1 is L+N_TAPS+2 cycles with continuous cfg_valid.
- Asynchronous reset mid-operation takes effect immediately: outputs go to their reset values and state goes to IDLE. Deassertion is sampled on clk. The first start can be recognised on the first edge after release.

## Test plan

- Reset, then N_TAPS=2, BW_coef=4: pulse cfg_mode and stream 1,0,1,0,0,0,1,1,0 with continuous cfg_valid. Required: coef_flat=0xA3 and cfg_done=1 on the edge after the 9th bit. fir_clr=1 for 2 cycles, then fir_en=1. cfg_err=0 throughout.
- From RUN with 0xA3: send 0,1,0,1,1,1,0,0,1 (parity error). Required: cfg_err=1, coef_flat stays 0xA3, and the block returns to RUN with fir_en=1 and no fir_clr pulse.
- From RUN, start a load and send 0,1,0,1,1,1,0,0,0 with cfg_valid gaps of 1–3 idle cycles between bits. Required: coef_flat=0x5C, cfg_done=1, fir_en first reasserts 3 cycles after the 9th accepted bit.
- From RUN with 0x5C: start a load, send 4 bits, drop cfg_mode. Required: cfg_err=1, coef_flat=0x5C, and fir_en=1 one cycle later. Repeat the same abort from a fresh reset: the block returns to IDLE with fir_en=0 and coef_flat=0.
- Hold cfg_mode high through a complete successful load. Required: no second LOAD entry and fir_en stays 1.
- Assert rst=0 mid-LOAD (after 5 bits) and separately mid-FLUSH. Required: every output is 0 immediately and asynchronously. After release, the block stays in IDLE until a fresh cfg_mode edge.

Source files
------------

// File: rtl/ttfir_cfg_ctrl.sv
// Configuration sequencer for the ttfir datapath: receives serial coefficient frames,
// checks even parity, commits coefficients atomically, flushes the delay line, then enables filtering.
module ttfir_cfg_ctrl #(
  parameter int N_TAPS  = 2,
  parameter int BW_coef = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_mode,
  input  logic                      i_cfg_valid,
  input  logic                      i_cfg_bit,
  output logic [N_TAPS*BW_coef-1:0] o_coef_flat,
  output logic                      o_fir_en,
  output logic                      o_fir_clr,
  output logic                      o_cfg_done,
  output logic                      o_cfg_err
);

  localparam int L  = N_TAPS*BW_coef + 1;
  localparam int CW = $clog2(L+1);
  localparam int FW = $clog2(N_TAPS+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_FLUSH, S_RUN} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [L-1:0]              r_shift;
  logic [CW-1:0]             r_count;
  logic [FW-1:0]             r_flush;
  logic                      r_mode_q;
  logic                      r_loaded;
  logic [N_TAPS*BW_coef-1:0] r_coef;
  logic                      r_fir_en;
  logic                      r_fir_clr;
  logic                      r_done;
  logic                      r_err;

  logic w_start;
  logic w_last;
  logic w_parity_ok;

  assign w_start     = i_cfg_mode & ~r_mode_q;
  assign w_last      = i_cfg_valid && (r_count == CW'(L-1));
  assign w_parity_ok = ~^r_shift;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      // Completion of the frame takes priority over a simultaneous abort.
      S_LOAD: begin
        if (w_last)           w_next = S_CHECK;
        else if (!i_cfg_mode) w_next = r_loaded ? S_RUN : S_IDLE;
      end
      S_CHECK: w_next = w_parity_ok ? S_FLUSH : (r_loaded ? S_RUN : S_IDLE);
      S_FLUSH: if (r_flush == FW'(N_TAPS)) w_next = S_RUN;
      S_RUN:   if (w_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Enable and clear are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_count   <= '0;
      r_flush   <= '0;
      r_mode_q  <= 1'b0;
      r_loaded  <= 1'b0;
      r_coef    <= '0;
      r_fir_en  <= 1'b0;
      r_fir_clr <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_mode_q  <= i_cfg_mode;
      r_fir_en  <= (w_next == S_RUN);
      r_fir_clr <= (w_next == S_FLUSH);
      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_start) begin
            r_count <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_last || (i_cfg_mode && i_cfg_valid)) begin
            r_shift <= {r_shift[L-2:0], i_cfg_bit};
            r_count <= r_count + 1'b1;
          end else if (!i_cfg_mode) begin
            r_err <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_parity_ok) begin
            r_coef   <= r_shift[L-1:1];
            r_done   <= 1'b1;
            r_loaded <= 1'b1;
            r_flush  <= FW'(1);
          end else begin
            r_err <= 1'b1;
          end
        end
        S_FLUSH: r_flush <= r_flush + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_coef_flat = r_coef;
  assign o_fir_en    = r_fir_en;
  assign o_fir_clr   = r_fir_clr;
  assign o_cfg_done  = r_done;
  assign o_cfg_err   = r_err;

endmodule

// File: tb/tb_ttfir_cfg_ctrl.sv
// Directed testbench for ttfir_cfg_ctrl (N_TAPS=2, BW_coef=4, 9-bit frames).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ttfir_cfg_ctrl;

  localparam int N_TAPS  = 2;
  localparam int BW_coef = 4;
  localparam int L       = N_TAPS*BW_coef + 1;

  logic                      clk;
  logic                      rst_n;
  logic                      cfgMode;
  logic                      cfgValid;
  logic                      cfgBit;
  logic [N_TAPS*BW_coef-1:0] coefFlat;
  logic                      firEn;
  logic                      firClr;
  logic                      cfgDone;
  logic                      cfgErr;

  int checks = 0;
  int errors = 0;

  ttfir_cfg_ctrl #(.N_TAPS(N_TAPS), .BW_coef(BW_coef)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_mode  (cfgMode),
    .i_cfg_valid (cfgValid),
    .i_cfg_bit   (cfgBit),
    .o_coef_flat (coefFlat),
    .o_fir_en    (firEn),
    .o_fir_clr   (firClr),
    .o_cfg_done  (cfgDone),
    .o_cfg_err   (cfgErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] coef, input logic en, input logic clr,
                          input logic done, input logic err);
    checkOutput({tag, ".coef"}, 32'(coefFlat), 32'(coef));
    checkOutput({tag, ".en"},   32'(firEn),    32'(en));
    checkOutput({tag, ".clr"},  32'(firClr),   32'(clr));
    checkOutput({tag, ".done"}, 32'(cfgDone),  32'(done));
    checkOutput({tag, ".err"},  32'(cfgErr),   32'(err));
  endtask

  // Sends the first nBits of a frame MSB-first; gapped inserts 1..3 idle cycles before each bit.
  task automatic applyStimulus(input logic [L-1:0] frame, input int nBits, input bit gapped);
    for (int i = 0; i < nBits; i++) begin
      if (gapped) begin
        cfgValid = 1'b0;
        repeat ((i % 3) + 1) @(negedge clk);
      end
      cfgValid = 1'b1;
      cfgBit   = frame[L-1-i];
      @(negedge clk);
    end
    cfgValid = 1'b0;
  endtask

  task automatic startLoad();
    cfgMode = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [L-1:0] frameA3;
    logic [L-1:0] frameBad;
    logic [L-1:0] frame5C;
    frameA3  = 9'b1010_0011_0;
    frameBad = 9'b0101_1100_1;
    frame5C  = 9'b0101_1100_0;

    rst_n    = 1'b0;
    cfgMode  = 1'b0;
    cfgValid = 1'b0;
    cfgBit   = 1'b0;
    repeat (2) @(negedge clk);
    checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] first load 0xA3, continuous valid");
    startLoad();
    checkOutput("t1.en_after_start", 32'(firEn), 32'd0);
    applyStimulus(frameA3, L, 1'b0);
    checkOutput("t1.done_in_check", 32'(cfgDone), 32'd0);
    cfgMode = 1'b0;
    @(negedge clk);
    checkAll("t1.commit", 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("t1.flush2", 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("t1.run", 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] parity error from RUN");
    startLoad();
    checkOutput("t2.en_after_start", 32'(firEn), 32'd0);
    checkOutput("t2.done_cleared", 32'(cfgDone), 32'd0);
    applyStimulus(frameBad, L, 1'b0);
    cfgMode = 1'b0;
    @(negedge clk);
    checkAll("t2.reject", 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkAll("t2.run", 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] gapped load 0x5C");
    startLoad();
    checkOutput("t3.err_cleared", 32'(cfgErr), 32'd0);
    applyStimulus(frame5C, L, 1'b1);
    cfgMode = 1'b0;
    @(negedge clk);
    checkAll("t3.commit", 8'h5C, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3.en_eL2", 32'(firEn), 32'd0);
    @(negedge clk);
    checkAll("t3.run", 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] abort from RUN");
    startLoad();
    applyStimulus(frameA3, 4, 1'b0);
    cfgMode = 1'b0;
    @(negedge clk);
    checkAll("t4.abort_run", 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] abort after fresh reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startLoad();
    applyStimulus(frameA3, 4, 1'b0);
    cfgMode = 1'b0;
    @(negedge clk);
    checkAll("t4.abort_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t4.idle_en", 32'(firEn), 32'd0);

    $display("[TB] cfg_mode held high through load");
    startLoad();
    applyStimulus(frameA3, L, 1'b0);
    repeat (3) @(negedge clk);
    checkAll("t5.run", 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkAll("t5.no_retrigger", 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
    cfgMode = 1'b0;
    @(negedge clk);

    $display("[TB] reset mid-LOAD");
    startLoad();
    applyStimulus(frame5C, 5, 1'b0);
    #2 rst_n = 1'b0;
    cfgMode = 1'b0;
    #1 checkAll("t6.load_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(frameA3, L, 1'b0);
    repeat (4) @(negedge clk);
    checkAll("t6.stay_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-FLUSH");
    startLoad();
    applyStimulus(frame5C, L, 1'b0);
    cfgMode = 1'b0;
    @(negedge clk);
    checkAll("t6.flush", 8'h5C, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkAll("t6.flush_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkAll("t6.after_flush_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] recovery load after reset");
    startLoad();
    applyStimulus(frameA3, L, 1'b0);
    cfgMode = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("t7.run", 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
